rr_prio_arbiter: RTL and testbench
==================================

Name: rr_prio_arbiter

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Built around a lowest-set-bit priority encoder. A rotating pointer decides which request line is searched first.
- Hold/lock handshake: a grantee keeps the grant while its request stays high, up to MAX_HOLD cycles.
- Forced rotation happens only when another requester is waiting. Sits in front of any shared datapath resource (bus port, shared ALU, memory port).

Parameters:
- N, 8, number of requesters (fixed at 8 for this revision).
- IDX_W, 3, width of the grant index (log2 N).
- MAX_HOLD, 4, maximum consecutive grant cycles while other requests are pending (legal 1..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  8  request lines; bit i is requester i, level-sensitive.
- grant  output  8  one-hot registered grant; all zero when idle.
- grant_valid  output  1  high while any grant is asserted.
- grant_idx  output  3  binary index of the granted requester; 0 when idle.

Behaviour:
- Design: one clock domain; reset is synchronous, active-high, sampled only on the rising edge of clk.
- Reset values: grant=0, grant_valid=0, grant_idx=0, ptr=0, hold_cnt=0, state=IDLE. Reset overrides all other activity, including mid-grant.
- Internal state: ptr[2:0] (search start), hold_cnt[3:0], state in {IDLE, GRANT}.
- Selection function sel(v, ptr):
  - m = v with bits below ptr cleared.
  - If m != 0, result = lowest set bit of m; otherwise result = lowest set bit of v.
  - Purely combinational; meaningful only when v != 0.
- Latency: req seen at edge k produces grant visible after edge k (one registered cycle). There is no combinational path from req to any output.
- IDLE:
  - If req != 0: grant_idx <= sel(req, ptr), grant <= onehot, grant_valid <= 1, hold_cnt <= 1, go to GRANT.
  - Otherwise stay in IDLE with outputs zero.
- GRANT, evaluated each edge with g = grant_idx:
  - Release (req[g]==0):
    - ptr <= g+1 mod 8 (7 wraps to 0).
    - If req != 0: grant sel(req, g+1) immediately, with no idle bubble, and set hold_cnt <= 1.
    - Otherwise: outputs go to 0 and state goes to IDLE.
  - Forced rotation (req[g]==1, hold_cnt==MAX_HOLD, (req & ~grant) != 0):
    - ptr <= g+1 mod 8.
    - Grant sel(req & ~grant, g+1), hold_cnt <= 1.
  - Hold (otherwise): grant unchanged, hold_cnt <= min(hold_cnt+1, MAX_HOLD).
- Sole requester: when no other request is pending, the grant is held indefinitely and hold_cnt saturates.
- Fairness: every continuously requesting line is granted within 7*MAX_HOLD+1 cycles.
- Invariants (bench asserts):
  - grant is one-hot or zero.
  - grant_valid == |grant.
  - When grant_valid, grant == 1 << grant_idx.
  - A grant never moves to a line whose req was low at the deciding edge.

Decomposition:
- Shared package arb_pkg:
  - N, IDX_W.
  - typedef req_vec_t (logic [N-1:0]).
  - typedef idx_t (logic [IDX_W-1:0]).
  - enum arb_state_t {IDLE, GRANT}.
- One sub-module, prio_enc8: combinational 8-bit lowest-set-bit encoder with outputs idx[2:0] and any.
  - Instantiated twice: once on the masked vector, once on the unmasked vector.
  - The top level selects between the two instances and owns ptr, hold_cnt and the FSM.

Test Plan:
- Single request: reset, then req=8'b0000_0100 → one cycle later grant=8'b0000_0100, grant_idx=2, grant_valid=1. Still held 20 cycles later.
- Handoff without bubble: from reset, req=8'h81 → grant_idx=0. Drop req[0] → next cycle grant_idx=7, with grant_valid never low in between.
- Forced rotation: MAX_HOLD=4, req=8'hFF held constantly → grant_idx sequence 0×4, 1×4, …, 7×4, then 0×4 (wrap). Exactly 4 cycles per index.
- Pointer wrap when idle:
  - Grant idx 1, then req=0 → valid=0 next cycle.
  - Then req=8'h03 → grant_idx=0, because ptr=2 finds no masked bits and the search wraps.
- Reset mid-grant: req=8'hF0, grant idx 4, then assert reset for one cycle → next cycle grant=0, valid=0. Then req=8'h88 → grant_idx=3 (ptr back at 0).
- Late arrival: req[5] alone held 10 cycles (hold_cnt saturated), then req[2] rises → req[5] rotated off on the next edge, grant_idx=2.

Source files
------------

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared types, sizes and helpers for the round-robin
//                priority arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    // Number of requesters and width of a binary requester index.
    localparam int N     = 8;
    localparam int IDX_W = 3;

    typedef logic [N-1:0]     req_vec_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Keeps bits at or above position p and clears everything below it.
    // This gives the "search from here upward" window used by the arbiter.
    function automatic req_vec_t mask_from(input idx_t p);
        req_vec_t m;
        for (int i = 0; i < N; i++) begin
            m[i] = (i >= int'(p));
        end
        return m;
    endfunction

    // Binary index to one-hot vector.
    function automatic req_vec_t onehot(input idx_t i);
        req_vec_t v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/prio_enc8.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc8
//  Description : Combinational 8-bit priority encoder; reports the index of
//                the lowest set bit and whether any bit is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_enc8
    import arb_pkg::*;
(
    input  req_vec_t vec,
    output idx_t     idx,
    output logic     any
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        idx = '0;
        any = |vec;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule : prio_enc8
`default_nettype wire

// File: rtl/rr_prio_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_prio_arbiter
//  Description : 8-way round-robin arbiter with hold/lock handshake. A
//                grantee keeps the grant while its request stays high; it is
//                rotated off after MAX_HOLD cycles only when another
//                requester is waiting. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_prio_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 4      // legal range 1..15
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    localparam logic [3:0] C_MAX_HOLD = 4'(MAX_HOLD);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t state_q, state_d;
    idx_t       ptr_q,   ptr_d;
    idx_t       idx_q,   idx_d;
    req_vec_t   grant_q, grant_d;
    logic       valid_q, valid_d;
    logic [3:0] hold_q,  hold_d;

    // ------------------------------------------------------------------
    // Selection datapath
    // ------------------------------------------------------------------
    idx_t     next_ptr;     // line after the current grantee (wraps 7->0)
    idx_t     search_start; // where the round-robin search begins
    req_vec_t cand;         // requesters eligible for a new grant
    req_vec_t cand_masked;  // eligible requesters at or above search_start
    idx_t     idx_masked;
    idx_t     idx_full;
    logic     any_masked;
    logic     any_full;
    idx_t     sel_idx;
    logic     others_waiting;

    // Search-window setup. Excluding the current grantee from the candidates
    // is harmless on release (its request is already low) and exactly what
    // forced rotation needs; in IDLE grant_q is zero so nothing is excluded.
    always_comb begin
        next_ptr       = idx_q + idx_t'(1);
        search_start   = (state_q == GRANT) ? next_ptr : ptr_q;
        cand           = req & ~grant_q;
        cand_masked    = cand & mask_from(search_start);
        others_waiting = |cand;
    end

    prio_enc8 u_enc_masked (
        .vec (cand_masked),
        .idx (idx_masked),
        .any (any_masked)
    );

    prio_enc8 u_enc_full (
        .vec (cand),
        .idx (idx_full),
        .any (any_full)
    );

    // Prefer the first candidate at/after the start point; if none exists
    // the search wraps and the lowest candidate overall wins.
    always_comb begin
        sel_idx = any_masked ? idx_masked : idx_full;
    end

    // ------------------------------------------------------------------
    // Next-state logic: grant, release, forced rotation and hold
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        valid_d = valid_q;
        hold_d  = hold_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    idx_d   = sel_idx;
                    grant_d = onehot(sel_idx);
                    valid_d = 1'b1;
                    hold_d  = 4'd1;
                end
            end

            GRANT: begin
                if (!req[idx_q]) begin
                    // Grantee released: hand off directly with no bubble.
                    ptr_d = next_ptr;
                    if (any_full) begin
                        idx_d   = sel_idx;
                        grant_d = onehot(sel_idx);
                        valid_d = 1'b1;
                        hold_d  = 4'd1;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                        grant_d = '0;
                        valid_d = 1'b0;
                        hold_d  = 4'd0;
                    end
                end else if ((hold_q == C_MAX_HOLD) && others_waiting) begin
                    // Hold budget spent and someone else is waiting.
                    ptr_d   = next_ptr;
                    idx_d   = sel_idx;
                    grant_d = onehot(sel_idx);
                    valid_d = 1'b1;
                    hold_d  = 4'd1;
                end else begin
                    // Keep the grant; the counter saturates so a sole
                    // requester can hold indefinitely.
                    if (hold_q < C_MAX_HOLD) begin
                        hold_d = hold_q + 4'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                idx_d   = '0;
                grant_d = '0;
                valid_d = 1'b0;
                hold_d  = 4'd0;
            end
        endcase
    end

    // State registers with synchronous reset that overrides any grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            hold_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
        end
    end

    // Outputs come straight from flops; no combinational path from req.
    always_comb begin
        grant       = grant_q;
        grant_valid = valid_q;
        grant_idx   = idx_q;
    end

endmodule : rr_prio_arbiter
`default_nettype wire

// File: tb/tb_rr_prio_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_prio_arbiter
//  Description : Self-checking bench for rr_prio_arbiter: directed scenarios
//                plus randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_prio_arbiter;

    localparam int MAX_HOLD = 4;
    localparam int LIMIT    = 7 * MAX_HOLD + 1;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic [7:0] grant;
    logic       grant_valid;
    logic [2:0] grant_idx;

    int n_checks;
    int n_errors;

    // Reference model state
    int m_ptr;
    int m_idx;
    bit m_act;
    int m_hold;

    // Fairness tracking
    int wait_cnt [8];
    int max_wait;

    rr_prio_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Circular search: first set bit at or after start, wrapping past 7.
    function automatic int sel(input logic [7:0] v, input int start);
        for (int k = 0; k < 8; k++) begin
            int j;
            j = (start + k) % 8;
            if (v[j]) return j;
        end
        return 0;
    endfunction

    task automatic model_step(input logic [7:0] r, input bit rst);
        logic [7:0] others;
        int g;
        if (rst) begin
            m_ptr = 0; m_idx = 0; m_act = 0; m_hold = 0;
        end else if (!m_act) begin
            if (r != 0) begin
                m_idx = sel(r, m_ptr); m_act = 1; m_hold = 1;
            end
        end else begin
            g = m_idx;
            if (!r[g]) begin
                m_ptr = (g + 1) % 8;
                if (r != 0) begin
                    m_idx = sel(r, m_ptr); m_hold = 1;
                end else begin
                    m_act = 0; m_idx = 0; m_hold = 0;
                end
            end else begin
                others = r & ~(8'd1 << g);
                if (m_hold == MAX_HOLD && others != 0) begin
                    m_ptr = (g + 1) % 8;
                    m_idx = sel(others, m_ptr);
                    m_hold = 1;
                end else if (m_hold < MAX_HOLD) begin
                    m_hold = m_hold + 1;
                end
            end
        end
    endtask

    // One clock: apply inputs, advance the model, compare after the edge.
    task automatic cycle(input logic [7:0] r, input bit rst);
        logic [7:0] prev_grant;
        logic [7:0] exp_grant;
        prev_grant = grant;
        req   = r;
        reset = rst;
        @(posedge clk);
        model_step(r, rst);
        #1;
        exp_grant = m_act ? (8'd1 << m_idx) : 8'd0;
        check("grant",       grant,       exp_grant);
        check("grant_valid", grant_valid, m_act);
        check("grant_idx",   grant_idx,   m_act ? m_idx : 0);
        check("onehot0",     $onehot0(grant), 1);
        check("valid_or",    grant_valid, |grant);
        if (grant_valid) check("idx_match", grant, 8'd1 << grant_idx);
        if (!rst && grant_valid && grant != prev_grant) check("move_to_req", r[grant_idx], 1);
        for (int i = 0; i < 8; i++) begin
            if (rst || !r[i] || (grant_valid && grant_idx == 3'(i))) wait_cnt[i] = 0;
            else wait_cnt[i]++;
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
    endtask

    task automatic do_reset();
        cycle(8'h00, 1'b1);
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] rq;
        n_checks = 0;
        n_errors = 0;
        max_wait = 0;
        for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
        m_ptr = 0; m_idx = 0; m_act = 0; m_hold = 0;
        reset = 1'b1;
        req   = 8'h00;
        @(posedge clk);
        #1;

        // Reset state
        do_reset();
        check("rst_grant", grant, 8'h00);
        check("rst_valid", grant_valid, 0);

        // Single request, held
        cycle(8'h04, 1'b0);
        check("single_idx", grant_idx, 2);
        check("single_grant", grant, 8'h04);
        for (int i = 0; i < 20; i++) cycle(8'h04, 1'b0);
        check("single_held", grant_idx, 2);

        // Handoff without bubble
        do_reset();
        cycle(8'h81, 1'b0);
        check("handoff_first", grant_idx, 0);
        cycle(8'h80, 1'b0);
        check("handoff_idx", grant_idx, 7);
        check("handoff_valid", grant_valid, 1);

        // Forced rotation with all lines requesting
        do_reset();
        for (int k = 0; k < 36; k++) begin
            cycle(8'hFF, 1'b0);
            check("rot_seq", grant_idx, (k / MAX_HOLD) % 8);
        end

        // Pointer wrap through idle
        do_reset();
        cycle(8'h02, 1'b0);
        check("wrap_first", grant_idx, 1);
        cycle(8'h00, 1'b0);
        check("wrap_idle", grant_valid, 0);
        cycle(8'h03, 1'b0);
        check("wrap_idx", grant_idx, 0);

        // Reset mid-grant
        do_reset();
        cycle(8'hF0, 1'b0);
        check("mid_first", grant_idx, 4);
        cycle(8'hF0, 1'b1);
        check("mid_rst_grant", grant, 8'h00);
        check("mid_rst_valid", grant_valid, 0);
        reset = 1'b0;
        cycle(8'h88, 1'b0);
        check("mid_after", grant_idx, 3);

        // Late arrival against a saturated sole requester
        do_reset();
        for (int i = 0; i < 10; i++) cycle(8'h20, 1'b0);
        check("late_hold", grant_idx, 5);
        cycle(8'h24, 1'b0);
        check("late_rot", grant_idx, 2);

        // Randomized traffic with persistent requests and rare resets
        do_reset();
        rq = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
            end
            if ($urandom_range(0, 199) == 0) cycle(rq, 1'b1);
            else cycle(rq, 1'b0);
        end
        reset = 1'b0;
        check("fairness", (max_wait <= LIMIT), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rr_prio_arbiter
`default_nettype wire
